gb_run_ctrl: RTL and testbench
==============================

Name: gb_run_ctrl

Overview:
- UART-driven run controller for the boy core; replaces the bare rx_valid halt toggle in the top level.
- Decodes single-byte commands from uart_rx and drives the core's halt gate and reset.
- Sequences run/halt, N-cycle single-step (counted in GB clock ticks) and timed core reset.
- Returns a one-byte acknowledge or status byte through a valid/ready handshake to the UART TX path.

Parameters:
- RST_CYCLES, 4096, number of clk cycles core_rst stays high for command 'X' (minimum 1).
- TIMEOUT, 1000000, number of clk cycles to wait for the step-count byte before aborting.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid in that cycle.
- rx_byte  in  8  received command or argument byte.
- gb_tick  in  1  one-cycle pulse per GB clock period, already synchronised to clk.
- halt  out  1  1 = core clock gated (held high).
- core_rst  out  1  active-high reset to the boy core.
- tx_valid  out  1  response byte available.
- tx_byte  out  8  response byte; stable while tx_valid=1.
- tx_ready  in  1  TX accepts the byte in any cycle where tx_valid=1 and tx_ready=1.

Behaviour:
- Reset values: halt=0, core_rst=0, tx_valid=0, tx_byte=0x00, ovr=0, state=IDLE, step count=0, timer=0.
- Command bytes, accepted in IDLE only:
  - 'H' (0x48): halt<=1, then ACK with 'K' (0x4B).
  - 'R' (0x52): halt<=0, then ACK with 'K'.
  - 'S' (0x53): go to GET_COUNT.
  - 'X' (0x58): go to RESET.
  - '?' (0x3F): ACK with status {halt, ovr, 6'b0}; ovr is cleared in the same cycle the status byte is latched.
  - Any other byte: ACK with '!' (0x21).
- GET_COUNT:
  - Timer counts clk cycles from entry.
  - A byte received here is the count N, with N=0x00 meaning 256. Latch N, set halt<=0, go to STEP. No command decoding happens in this state.
  - If the timer reaches TIMEOUT-1 with no byte: ACK '!' and halt is unchanged.
- STEP:
  - Each gb_tick decrements the remaining count.
  - On the gb_tick that takes the count from 1 to 0: halt<=1 on that edge, so exactly N ticks have run. Then ACK 'K'.
  - If gb_tick arrives in the cycle STEP is entered, it is not counted; counting starts the following cycle.
- RESET:
  - core_rst<=1 for exactly RST_CYCLES clk cycles, then core_rst<=0 and ACK 'K'.
  - halt is unchanged, so a halted core stays halted after reset.
- ACK:
  - tx_byte is registered on entry and tx_valid<=1.
  - On a cycle with tx_valid & tx_ready: tx_valid<=0 on the next edge and state returns to IDLE.
  - Minimum of one idle cycle between responses.
- Overrun:
  - rx_valid in STEP, RESET or ACK sets the sticky ovr bit and the byte is discarded.
  - rx_valid in IDLE or GET_COUNT never sets ovr.
- Simultaneous events: rx_valid and tx handshake in the same ACK cycle → the byte is dropped and ovr is set.
- Reset mid-operation: rst asserted in any state returns all outputs to reset values immediately (asynchronous). An in-flight step is abandoned, core_rst is released and any pending ack is lost.
- Widths:
  - Step counter is 9 bits (range 1..256).
  - Reset timer and timeout timer share one counter of width clog2(max(RST_CYCLES, TIMEOUT)).
  - No wrap: counters saturate at their terminal value.

Test Plan:
- Reset then 'H': halt=1 one cycle after rx_valid; tx_valid=1 with tx_byte=0x4B; hold tx_ready=0 for 5 cycles → byte stays stable; tx_ready=1 → tx_valid=0 next cycle.
- With halt=1, send 'S' then 0x03, gb_tick every 6 clks: halt=0 for exactly 3 ticks, then halt=1 on the 3rd tick edge; ack 0x4B. Repeat with 0x00 → exactly 256 ticks.
- 'X' with RST_CYCLES=16: core_rst high for exactly 16 clks; halt is unchanged; ack 0x4B.
- 'S' then no byte, TIMEOUT=100: ack 0x21 after 100 clks; halt is unchanged. Also send 0x5A in IDLE → ack 0x21.
- During a step send 0x48 → step finishes unaffected; '?' then returns 0xC0 (halt=1, ovr=1); a second '?' returns 0x80.
- Assert rst mid-STEP and mid-RESET: halt=0, core_rst=0 and tx_valid=0 in the same cycle; a subsequent 'R' is accepted normally.

Source files
------------

// File: rtl/gb_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : gb_run_ctrl_if
// Description : Byte-wide UART command/response link for the run controller.
//               rx_valid/rx_byte carry received command and argument bytes
//               (one-cycle strobe). tx_valid/tx_byte/tx_ready carry the
//               response byte under a valid/ready handshake.
//               master : UART side (drives rx, consumes tx)
//               slave  : controller side (consumes rx, drives tx)
// Revision    : 1.0 - initial release
// ============================================================================
interface gb_run_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready;

  modport master (
    output rx_valid,
    output rx_byte,
    input  tx_valid,
    input  tx_byte,
    output tx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_byte,
    output tx_valid,
    output tx_byte,
    input  tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/gb_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gb_run_ctrl
// Description : UART-driven run controller for the boy core. Decodes single
//               byte commands and drives the core halt gate and core reset.
//               'H' halt, 'R' run, 'S'+N step N GB ticks (0 = 256),
//               'X' timed core reset, '?' status {halt, ovr, 6'b0}.
//               Every command ends with one response byte on the TX link.
// Ports       : clk      - system clock (rising edge)
//               rst      - asynchronous active-high reset
//               gb_tick  - one-cycle pulse per GB clock period (clk domain)
//               halt     - 1 = core clock gated
//               core_rst - active-high reset to the boy core
//               bus      - rx command bytes in, tx response bytes out
// Revision    : 1.0 - initial release
// ============================================================================
module gb_run_ctrl #(
  parameter int RST_CYCLES = 4096,
  parameter int TIMEOUT    = 1000000
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       gb_tick,
  output logic            halt,
  output logic            core_rst,
  gb_run_ctrl_if.slave    bus
);

  // One timer serves both the reset pulse and the step-count timeout.
  localparam int TMAX = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [7:0] CMD_HALT   = 8'h48;
  localparam logic [7:0] CMD_RUN    = 8'h52;
  localparam logic [7:0] CMD_STEP   = 8'h53;
  localparam logic [7:0] CMD_RESET  = 8'h58;
  localparam logic [7:0] CMD_STATUS = 8'h3F;
  localparam logic [7:0] RSP_OK     = 8'h4B;
  localparam logic [7:0] RSP_ERR    = 8'h21;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_COUNT = 3'd1,
    ST_STEP      = 3'd2,
    ST_RESET     = 3'd3,
    ST_ACK       = 3'd4
  } state_t;

  state_t        r_state,    w_state_n;
  logic          r_halt,     w_halt_n;
  logic          r_core_rst, w_core_rst_n;
  logic          r_tx_valid, w_tx_valid_n;
  logic [7:0]    r_tx_byte,  w_tx_byte_n;
  logic          r_ovr,      w_ovr_n;
  logic [8:0]    r_count,    w_count_n;
  logic [TW-1:0] r_timer,    w_timer_n;

  // Response launch request raised by any state that finishes a command.
  logic          w_ack_go;
  logic [7:0]    w_ack_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_halt     <= 1'b0;
      r_core_rst <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_ovr      <= 1'b0;
      r_count    <= 9'd0;
      r_timer    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_halt     <= w_halt_n;
      r_core_rst <= w_core_rst_n;
      r_tx_valid <= w_tx_valid_n;
      r_tx_byte  <= w_tx_byte_n;
      r_ovr      <= w_ovr_n;
      r_count    <= w_count_n;
      r_timer    <= w_timer_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_halt_n     = r_halt;
    w_core_rst_n = r_core_rst;
    w_tx_valid_n = r_tx_valid;
    w_tx_byte_n  = r_tx_byte;
    w_ovr_n      = r_ovr;
    w_count_n    = r_count;
    w_timer_n    = r_timer;
    w_ack_go     = 1'b0;
    w_ack_byte   = RSP_OK;

    case (r_state)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_byte)
            CMD_HALT: begin
              w_halt_n = 1'b1;
              w_ack_go = 1'b1;
            end
            CMD_RUN: begin
              w_halt_n = 1'b0;
              w_ack_go = 1'b1;
            end
            CMD_STEP: begin
              w_state_n = ST_GET_COUNT;
              w_timer_n = '0;
            end
            CMD_RESET: begin
              w_state_n    = ST_RESET;
              w_timer_n    = '0;
              w_core_rst_n = 1'b1;
            end
            CMD_STATUS: begin
              // Status reports ovr as it was, then clears it on the same edge.
              w_ack_go   = 1'b1;
              w_ack_byte = {r_halt, r_ovr, 6'b0};
              w_ovr_n    = 1'b0;
            end
            default: begin
              w_ack_go   = 1'b1;
              w_ack_byte = RSP_ERR;
            end
          endcase
        end
      end

      ST_GET_COUNT: begin
        // Any byte here is the argument; it is never decoded as a command.
        if (bus.rx_valid) begin
          w_count_n = (bus.rx_byte == 8'h00) ? 9'd256 : {1'b0, bus.rx_byte};
          w_halt_n  = 1'b0;
          w_state_n = ST_STEP;
        end else if (r_timer == TO_LAST) begin
          w_ack_go   = 1'b1;
          w_ack_byte = RSP_ERR;
        end else begin
          w_timer_n = r_timer + 1'b1;
        end
      end

      ST_STEP: begin
        if (bus.rx_valid) begin
          w_ovr_n = 1'b1;
        end
        if (gb_tick) begin
          // Gate the core on the edge of the last tick so exactly N ticks run.
          if (r_count <= 9'd1) begin
            w_count_n = 9'd0;
            w_halt_n  = 1'b1;
            w_ack_go  = 1'b1;
          end else begin
            w_count_n = r_count - 9'd1;
          end
        end
      end

      ST_RESET: begin
        if (bus.rx_valid) begin
          w_ovr_n = 1'b1;
        end
        if (r_timer == RST_LAST) begin
          w_core_rst_n = 1'b0;
          w_ack_go     = 1'b1;
        end else begin
          w_timer_n = r_timer + 1'b1;
        end
      end

      ST_ACK: begin
        if (bus.rx_valid) begin
          w_ovr_n = 1'b1;
        end
        if (r_tx_valid && bus.tx_ready) begin
          w_tx_valid_n = 1'b0;
          w_state_n    = ST_IDLE;
        end
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    if (w_ack_go) begin
      w_state_n    = ST_ACK;
      w_tx_valid_n = 1'b1;
      w_tx_byte_n  = w_ack_byte;
    end
  end

  assign halt        = r_halt;
  assign core_rst    = r_core_rst;
  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_byte  = r_tx_byte;

endmodule
`default_nettype wire

// File: tb/tb_gb_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gb_run_ctrl
// Description : Self-checking bench for gb_run_ctrl. Expected halt/ovr state
//               is tracked per command; executed GB ticks are counted from the
//               observable halt gate and compared with the requested count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_run_ctrl;

  localparam int RST_CYC = 16;
  localparam int TMO     = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gb_tick = 1'b0;
  logic halt;
  logic core_rst;

  gb_run_ctrl_if bus ();

  gb_run_ctrl #(
    .RST_CYCLES (RST_CYC),
    .TIMEOUT    (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .gb_tick  (gb_tick),
    .halt     (halt),
    .core_rst (core_rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: what halt and ovr must be after each command.
  logic exp_halt = 1'b0;
  logic exp_ovr  = 1'b0;

  // GB tick source.
  logic tick_en     = 1'b0;
  int   tick_period = 6;
  int   tick_cnt    = 0;

  always begin
    @(posedge clk);
    #1;
    if (tick_en) begin
      if (tick_cnt >= tick_period - 1) begin
        gb_tick  = 1'b1;
        tick_cnt = 0;
      end else begin
        gb_tick  = 1'b0;
        tick_cnt = tick_cnt + 1;
      end
    end else begin
      gb_tick  = 1'b0;
      tick_cnt = 0;
    end
  end

  // Ticks the core actually executed: a tick counts when the gate is open.
  int ran_total = 0;
  always @(posedge clk) begin
    if (gb_tick && !halt) ran_total <= ran_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    clk_step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic take_ack(input string tag, input logic [7:0] exp);
    int cyc = 0;
    int d;
    while (!bus.tx_valid && cyc < 400) begin
      clk_step();
      cyc++;
    end
    check({tag, "_valid"}, bus.tx_valid, 1);
    check({tag, "_byte"}, bus.tx_byte, exp);
    d = $urandom_range(0, 3);
    repeat (d) clk_step();
    bus.tx_ready = 1'b1;
    clk_step();
    bus.tx_ready = 1'b0;
    check({tag, "_drop"}, bus.tx_valid, 0);
    clk_step();
  endtask

  task automatic status(input string tag);
    send(8'h3F);
    take_ack(tag, {exp_halt, exp_ovr, 6'b0});
    exp_ovr = 1'b0;
  endtask

  // Step N ticks from a halted core; optionally inject a byte mid-step.
  task automatic do_step(input logic [7:0] nb, input int period, input int inject, input string tag);
    int n_exp = (nb == 8'h00) ? 256 : int'(nb);
    int r0;
    int cyc = 0;
    send(8'h53);
    send(nb);
    check({tag, "_open"}, halt, 0);
    r0          = ran_total;
    tick_period = period;
    tick_en     = 1'b1;
    while (!bus.tx_valid && cyc < 5000) begin
      if (cyc == inject) begin
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h48;
        exp_ovr      = 1'b1;
      end else begin
        bus.rx_valid = 1'b0;
      end
      clk_step();
      cyc++;
    end
    bus.rx_valid = 1'b0;
    tick_en      = 1'b0;
    check({tag, "_gated"}, halt, 1);
    check({tag, "_ticks"}, ran_total - r0, n_exp);
    exp_halt = 1'b1;
    take_ack(tag, 8'h4B);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.tx_ready = 1'b0;
    repeat (3) clk_step();
    rst = 1'b0;
    clk_step();

    // Reset state.
    check("rst_halt", halt, 0);
    check("rst_core_rst", core_rst, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_byte", bus.tx_byte, 8'h00);

    // 'H' with backpressure: byte must stay put until accepted.
    send(8'h48);
    exp_halt = 1'b1;
    check("h_halt", halt, 1);
    check("h_valid", bus.tx_valid, 1);
    check("h_byte", bus.tx_byte, 8'h4B);
    for (int i = 0; i < 5; i++) begin
      clk_step();
      check("h_hold_valid", bus.tx_valid, 1);
      check("h_hold_byte", bus.tx_byte, 8'h4B);
    end
    bus.tx_ready = 1'b1;
    clk_step();
    bus.tx_ready = 1'b0;
    check("h_release", bus.tx_valid, 0);
    clk_step();

    // Single-step: 3 ticks, then the 256 encoding, then random counts.
    do_step(8'h03, 6, -1, "step3");
    do_step(8'h00, 6, -1, "step256");
    for (int k = 0; k < 4; k++) begin
      do_step(8'($urandom_range(1, 40)), $urandom_range(1, 5), -1, "step_rnd");
    end

    // Timed core reset keeps the core halted.
    begin
      int hi = 0;
      send(8'h58);
      while (core_rst && hi < 200) begin
        check("x_halt_kept", halt, exp_halt);
        clk_step();
        hi++;
      end
      check("x_width", hi, RST_CYC);
      take_ack("x_ack", 8'h4B);
      check("x_halt_after", halt, exp_halt);
    end

    // Missing step count times out.
    begin
      int wcyc = 0;
      send(8'h53);
      while (!bus.tx_valid && wcyc < 1000) begin
        clk_step();
        wcyc++;
      end
      check("tmo_cycles", wcyc, TMO);
      check("tmo_halt", halt, exp_halt);
      take_ack("tmo_ack", 8'h21);
    end

    // Unknown commands.
    send(8'h5A);
    take_ack("bad_5a", 8'h21);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      while (b == 8'h48 || b == 8'h52 || b == 8'h53 || b == 8'h58 || b == 8'h3F) begin
        b = b + 8'd1;
      end
      send(b);
      take_ack("bad_rnd", 8'h21);
    end

    // Byte during step is an overrun and does not disturb the step.
    do_step(8'd20, 6, 10, "step_ovr");
    status("stat_ovr");
    status("stat_clr");

    // Byte arriving in the same cycle as the handshake is dropped.
    send(8'h52);
    exp_halt = 1'b0;
    check("run_halt", halt, 0);
    bus.tx_ready = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h48;
    clk_step();
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    exp_ovr      = 1'b1;
    check("coll_drop", bus.tx_valid, 0);
    check("coll_halt", halt, 0);
    clk_step();
    status("stat_coll");

    // Reset in the middle of a step.
    send(8'h48);
    exp_halt = 1'b1;
    take_ack("h2", 8'h4B);
    send(8'h53);
    send(8'd50);
    tick_period = 2;
    tick_en     = 1'b1;
    repeat (20) clk_step();
    rst = 1'b1;
    #1;
    check("rstep_halt", halt, 0);
    check("rstep_core_rst", core_rst, 0);
    check("rstep_tx_valid", bus.tx_valid, 0);
    tick_en = 1'b0;
    clk_step();
    rst = 1'b0;
    exp_halt = 1'b0;
    exp_ovr  = 1'b0;
    clk_step();

    // Reset in the middle of a core reset.
    send(8'h58);
    repeat (5) clk_step();
    check("rrst_active", core_rst, 1);
    rst = 1'b1;
    #1;
    check("rrst_core_rst", core_rst, 0);
    check("rrst_halt", halt, 0);
    check("rrst_tx_valid", bus.tx_valid, 0);
    clk_step();
    rst = 1'b0;
    clk_step();

    send(8'h52);
    take_ack("r_after", 8'h4B);
    check("r_after_halt", halt, 0);
    status("stat_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
